// File: rtl/dmem_mmio_bridge_pkg.sv
// Shared constants for the data-memory / MMIO bridge:
// MMIO page offsets, STATUS bit positions and the default page base.
package dmem_mmio_bridge_pkg;

    localparam logic [31:0] MMIO_BASE_DEF = 32'hFFFF_F000;

    localparam logic [11:0] OFF_LED       = 12'h000;
    localparam logic [11:0] OFF_SWITCH    = 12'h001;
    localparam logic [11:0] OFF_TIMER_CNT = 12'h002;
    localparam logic [11:0] OFF_TIMER_CMP = 12'h003;
    localparam logic [11:0] OFF_STATUS    = 12'h004;
    localparam logic [11:0] OFF_TX_DATA   = 12'h005;

    localparam int STAT_MATCH = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_EMPTY = 2;
    localparam int STAT_OVF   = 3;

endpackage

// File: rtl/dmem_mmio_bridge_mmio_tx_fifo.sv
// Byte-wide TX FIFO with sticky overflow flag.
// Ports: clock/reset, push/push_data, pop_req, ovf_clr -> head/full/empty/overflow.
module mmio_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop_req,
    input  logic       ovf_clr,
    output logic [7:0] head,
    output logic       full,
    output logic       empty,
    output logic       overflow
);

    localparam int PW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          r_ovf;

    logic w_pop;
    logic w_push;
    logic w_drop;

    assign empty    = (r_count == '0);
    assign full     = (r_count == (PW+1)'(DEPTH));
    assign overflow = r_ovf;
    // Head is masked when empty so a stale entry never shows on tx_data.
    assign head     = empty ? 8'd0 : r_mem[r_rd_ptr];

    assign w_pop  = pop_req & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push = push & (~full | w_pop);
    assign w_drop = push & full & ~w_pop;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'd0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
            // Set beats a simultaneous clear.
            r_ovf <= w_drop | (r_ovf & ~ovf_clr);
        end
    end

endmodule

// File: rtl/dmem_mmio_bridge.sv
// Decodes processor data accesses to the data RAM or the MMIO page
// (LEDs, synced switches, timer/compare irq, TX FIFO); read data is combinational.
module dmem_mmio_bridge
    import dmem_mmio_bridge_pkg::*;
#(
    parameter int          RAM_ADDR_W = 12,
    parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEF,
    parameter int          TX_DEPTH   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           proc_addr,
    input  logic [31:0]           proc_wdata,
    input  logic                  proc_wren,
    output logic [31:0]           proc_rdata,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    output logic                  ram_wren,
    input  logic [31:0]           ram_q,
    input  logic [15:0]           switches_in,
    output logic [15:0]           leds,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  irq
);

    logic [15:0] r_leds;
    logic [15:0] r_sw_meta;
    logic [15:0] r_sw_sync;
    logic [31:0] r_count;
    logic [31:0] r_cmp;
    logic        r_match;

    logic        w_ram_hit;
    logic        w_mmio_hit;
    logic [11:0] w_off;
    logic        w_sel_led;
    logic        w_sel_sw;
    logic        w_sel_cnt;
    logic        w_sel_cmp;
    logic        w_sel_stat;
    logic        w_sel_tx;
    logic        w_match_set;
    logic        w_match_clr;
    logic        w_full;
    logic        w_empty;
    logic        w_ovf;
    logic [31:0] w_status;

    assign w_ram_hit  = ((proc_addr >> RAM_ADDR_W) == 32'd0);
    assign w_mmio_hit = (proc_addr[31:12] == MMIO_BASE[31:12]);
    assign w_off      = proc_addr[11:0];

    assign w_sel_led  = w_mmio_hit & (w_off == OFF_LED);
    assign w_sel_sw   = w_mmio_hit & (w_off == OFF_SWITCH);
    assign w_sel_cnt  = w_mmio_hit & (w_off == OFF_TIMER_CNT);
    assign w_sel_cmp  = w_mmio_hit & (w_off == OFF_TIMER_CMP);
    assign w_sel_stat = w_mmio_hit & (w_off == OFF_STATUS);
    assign w_sel_tx   = w_mmio_hit & (w_off == OFF_TX_DATA);

    assign ram_addr  = proc_addr[RAM_ADDR_W-1:0];
    assign ram_wdata = proc_wdata;
    assign ram_wren  = proc_wren & w_ram_hit;

    assign leds     = r_leds;
    assign tx_valid = ~w_empty;
    assign irq      = r_match;

    // Compare against the registered count, so match lands one cycle
    // after the count shows the compare value.
    assign w_match_set = (r_count == r_cmp);
    assign w_match_clr = proc_wren & w_sel_stat & proc_wdata[STAT_MATCH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_leds    <= 16'd0;
            r_sw_meta <= 16'd0;
            r_sw_sync <= 16'd0;
        end else begin
            if (proc_wren & w_sel_led) begin
                r_leds <= proc_wdata[15:0];
            end
            r_sw_meta <= switches_in;
            r_sw_sync <= r_sw_meta;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= 32'd0;
            r_cmp   <= 32'hFFFF_FFFF;
            r_match <= 1'b0;
        end else begin
            r_count <= (proc_wren & w_sel_cnt) ? proc_wdata : r_count + 32'd1;
            if (proc_wren & w_sel_cmp) begin
                r_cmp <= proc_wdata;
            end
            r_match <= w_match_set | (r_match & ~w_match_clr);
        end
    end

    mmio_tx_fifo #(
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (proc_wren & w_sel_tx),
        .push_data (proc_wdata[7:0]),
        .pop_req   (tx_ready),
        .ovf_clr   (proc_wren & w_sel_stat & proc_wdata[STAT_OVF]),
        .head      (tx_data),
        .full      (w_full),
        .empty     (w_empty),
        .overflow  (w_ovf)
    );

    always_comb begin
        w_status             = 32'd0;
        w_status[STAT_MATCH] = r_match;
        w_status[STAT_FULL]  = w_full;
        w_status[STAT_EMPTY] = w_empty;
        w_status[STAT_OVF]   = w_ovf;
    end

    always_comb begin
        proc_rdata = 32'd0;
        unique case (1'b1)
            w_ram_hit:  proc_rdata = ram_q;
            w_sel_led:  proc_rdata = {16'd0, r_leds};
            w_sel_sw:   proc_rdata = {16'd0, r_sw_sync};
            w_sel_cnt:  proc_rdata = r_count;
            w_sel_cmp:  proc_rdata = r_cmp;
            w_sel_stat: proc_rdata = w_status;
            default:    proc_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Directed self-checking bench for dmem_mmio_bridge.
// Drives processor accesses, models the data RAM, checks MMIO/FIFO/timer behaviour.
module tb_dmem_mmio_bridge;

    localparam logic [31:0] A_LED  = 32'hFFFF_F000;
    localparam logic [31:0] A_SW   = 32'hFFFF_F001;
    localparam logic [31:0] A_CNT  = 32'hFFFF_F002;
    localparam logic [31:0] A_CMP  = 32'hFFFF_F003;
    localparam logic [31:0] A_STAT = 32'hFFFF_F004;
    localparam logic [31:0] A_TX   = 32'hFFFF_F005;
    localparam logic [31:0] A_UNM  = 32'hFFFF_F7FF;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] proc_addr = 32'd0;
    logic [31:0] proc_wdata = 32'd0;
    logic        proc_wren = 1'b0;
    logic [31:0] proc_rdata;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_wren;
    logic [31:0] ram_q;
    logic [15:0] switches_in = 16'd0;
    logic [15:0] leds;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] ram_mem [4096];

    always #5 clock = ~clock;

    assign ram_q = ram_mem[ram_addr];

    always @(posedge clock) begin
        if (ram_wren) ram_mem[ram_addr] <= ram_wdata;
    end

    dmem_mmio_bridge dut (
        .clock       (clock),
        .reset       (reset),
        .proc_addr   (proc_addr),
        .proc_wdata  (proc_wdata),
        .proc_wren   (proc_wren),
        .proc_rdata  (proc_rdata),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q),
        .switches_in (switches_in),
        .leds        (leds),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .irq         (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        proc_addr  = a;
        proc_wdata = d;
        proc_wren  = 1'b1;
        step();
        proc_wren  = 1'b0;
    endtask

    task automatic rdchk(input string tag, input logic [31:0] a,
                         input logic [31:0] exp);
        proc_addr = a;
        proc_wren = 1'b0;
        #1;
        chk(tag, proc_rdata, exp);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_leds", 32'(leds), 32'h0);
        chk("rst_txv", 32'(tx_valid), 32'h0);
        chk("rst_txd", 32'(tx_data), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        step(); step(); step();
        reset = 1'b1;
        step();

        rdchk("rd_led", A_LED, 32'h0);
        rdchk("rd_cmp", A_CMP, 32'hFFFF_FFFF);
        rdchk("rd_stat", A_STAT, 32'h4);
        rdchk("rd_unm", A_UNM, 32'h0);
        rdchk("rd_tx", A_TX, 32'h0);
        step();

        // RAM passthrough
        proc_addr = 32'd5; proc_wdata = 32'h1234; proc_wren = 1'b1;
        #1;
        chk("ram_wren_hi", 32'(ram_wren), 32'h1);
        chk("ram_addr", 32'(ram_addr), 32'h5);
        chk("ram_wdata", ram_wdata, 32'h1234);
        step();
        proc_wren = 1'b0;
        #1;
        chk("ram_wren_lo", 32'(ram_wren), 32'h0);
        rdchk("ram_rd", 32'd5, 32'h1234);
        step();

        // Unmapped write must not reach the RAM even though low bits alias
        proc_addr = 32'h0000_1005; proc_wdata = 32'h77; proc_wren = 1'b1;
        #1;
        chk("unm_wren", 32'(ram_wren), 32'h0);
        step();
        proc_wren = 1'b0;
        rdchk("unm_rd", 32'h0000_1005, 32'h0);
        rdchk("ram_keep", 32'd5, 32'h1234);
        step();

        // LED write, MMIO write must not reach RAM
        proc_addr = A_LED; proc_wdata = 32'hFFFF_A5A5; proc_wren = 1'b1;
        #1;
        chk("led_no_ram", 32'(ram_wren), 32'h0);
        step();
        proc_wren = 1'b0;
        chk("leds", 32'(leds), 32'hA5A5);
        rdchk("rd_led2", A_LED, 32'h0000_A5A5);

        // Switch synchronizer: two-cycle latency
        step();
        switches_in = 16'hBEEF;
        step();
        rdchk("sw_1cyc", A_SW, 32'h0);
        step();
        rdchk("sw_2cyc", A_SW, 32'h0000_BEEF);

        // Timer: wrap, compare, sticky match, W1C
        wr(A_CMP, 32'h1);
        wr(A_CNT, 32'hFFFF_FFFE);
        rdchk("cnt_load", A_CNT, 32'hFFFF_FFFE);
        step();
        rdchk("cnt_ff", A_CNT, 32'hFFFF_FFFF);
        step();
        rdchk("cnt_wrap", A_CNT, 32'h0);
        step();
        rdchk("cnt_1", A_CNT, 32'h1);
        chk("irq_pre", 32'(irq), 32'h0);
        step();
        chk("irq_set", 32'(irq), 32'h1);
        rdchk("stat_match", A_STAT, 32'h5);
        wr(A_CNT, 32'h0);
        step();
        wr(A_STAT, 32'h1);
        chk("w1c_vs_set", 32'(irq), 32'h1);
        wr(A_STAT, 32'h1);
        chk("w1c_clr", 32'(irq), 32'h0);
        rdchk("stat_clr", A_STAT, 32'h4);

        // FIFO overflow and in-order drain
        tx_ready = 1'b0;
        proc_addr = A_TX; proc_wdata = 32'h11; proc_wren = 1'b1;
        #1;
        chk("no_bypass", 32'(tx_valid), 32'h0);
        step();
        proc_wren = 1'b0;
        chk("txv_rise", 32'(tx_valid), 32'h1);
        chk("txd_head", 32'(tx_data), 32'h11);
        wr(A_TX, 32'h22);
        wr(A_TX, 32'h33);
        wr(A_TX, 32'h44);
        rdchk("stat_full", A_STAT, 32'h2);
        wr(A_TX, 32'h55);
        rdchk("stat_ovf", A_STAT, 32'hA);
        tx_ready = 1'b1;
        #1;
        chk("drain0", 32'(tx_data), 32'h11);
        step();
        chk("drain1", 32'(tx_data), 32'h22);
        step();
        chk("drain2", 32'(tx_data), 32'h33);
        step();
        chk("drain3", 32'(tx_data), 32'h44);
        step();
        chk("drain_v0", 32'(tx_valid), 32'h0);
        rdchk("stat_empty", A_STAT, 32'hC);
        tx_ready = 1'b0;
        wr(A_STAT, 32'h8);
        rdchk("ovf_w1c", A_STAT, 32'h4);

        // Full FIFO, push with simultaneous pop
        wr(A_TX, 32'h11);
        wr(A_TX, 32'h22);
        wr(A_TX, 32'h33);
        wr(A_TX, 32'h44);
        proc_addr = A_TX; proc_wdata = 32'h99; proc_wren = 1'b1;
        tx_ready = 1'b1;
        step();
        proc_wren = 1'b0;
        tx_ready = 1'b0;
        rdchk("pp_full", A_STAT, 32'h2);
        chk("pp0", 32'(tx_data), 32'h22);
        tx_ready = 1'b1;
        step();
        chk("pp1", 32'(tx_data), 32'h33);
        step();
        chk("pp2", 32'(tx_data), 32'h44);
        step();
        chk("pp3", 32'(tx_data), 32'h99);
        step();
        chk("pp_v0", 32'(tx_valid), 32'h0);
        rdchk("pp_stat", A_STAT, 32'h4);
        tx_ready = 1'b0;

        // Async reset mid-drain
        wr(A_CNT, 32'h0);
        step();
        step();
        chk("irq_pre_rst", 32'(irq), 32'h1);
        wr(A_TX, 32'hAA);
        wr(A_TX, 32'hBB);
        wr(A_TX, 32'hCC);
        tx_ready = 1'b1;
        #1;
        chk("mid_head", 32'(tx_data), 32'hAA);
        step();
        chk("mid_next", 32'(tx_data), 32'hBB);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_txv", 32'(tx_valid), 32'h0);
        chk("ar_txd", 32'(tx_data), 32'h0);
        chk("ar_irq", 32'(irq), 32'h0);
        chk("ar_leds", 32'(leds), 32'h0);
        step();
        step();
        reset = 1'b1;
        tx_ready = 1'b0;
        step();
        rdchk("post_stat", A_STAT, 32'h4);
        rdchk("post_cmp", A_CMP, 32'hFFFF_FFFF);
        wr(A_TX, 32'hCD);
        chk("post_txv", 32'(tx_valid), 32'h1);
        chk("post_txd", 32'(tx_data), 32'hCD);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
